risci_memory: RTL and testbench

RISCI_MEMORY -- requirements
Module: risci_memory

---
 rtl/risci_pkg.sv | 22 ++
 rtl/risci_lane_merge.sv | 22 ++
 rtl/risci_memory.sv | 127 ++++++++++++
 tb/tb_risci_memory.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/risci_pkg.sv
// Shared definitions for the risci memory slice: widths, size codes, FSM states
// and the byte-enable helper used by the store path.
package risci_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int DLEN = 64;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_e;
  typedef enum logic [1:0] {RQ_LD = 2'd0, RQ_ST = 2'd1, RQ_ERR = 2'd2} req_e;

  function automatic logic [7:0] byte_mask(input size_e sz, input logic [2:0] off);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m << off;
  endfunction
endpackage

// File: rtl/risci_lane_merge.sv
// Store-data merge: replaces only the byte lanes covered by size/offset,
// keeping every other byte of the old word.
module risci_lane_merge
  import risci_pkg::*;
(
  input  size_e            size,
  input  logic [2:0]       offset,
  input  logic [DLEN-1:0]  old_word,
  input  logic [DLEN-1:0]  new_data,
  output logic [DLEN-1:0]  merged
);
  logic [7:0]      bmask;
  logic [DLEN-1:0] shifted;

  always_comb begin
    bmask   = byte_mask(size, offset);
    shifted = new_data << {offset, 3'b000};
    merged  = old_word;
    for (int i = 0; i < 8; i++)
      if (bmask[i]) merged[i*8 +: 8] = shifted[i*8 +: 8];
  end
endmodule

// File: rtl/risci_memory.sv
// Dual-port (fetch + data) memory model with a fixed-latency data port,
// sub-word loads/stores, and error reporting for bad accesses.
module risci_memory
  import risci_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int LAT   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] iaddr,
  output logic [ILEN-1:0] iout,
  input  logic [XLEN-1:0] daddr,
  input  logic [XLEN-1:0] din,
  output logic [DLEN-1:0] dout,
  input  logic [1:0]      dlen,
  input  logic            re,
  input  logic            we,
  output logic            dready,
  output logic            derr
);
  localparam int AW = $clog2(DEPTH);

  logic [DLEN-1:0] mem [DEPTH];

  state_e          state_q;
  logic [3:0]      cnt_q;
  req_e            kind_q;
  size_e           size_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic            dready_q, derr_q;
  logic [DLEN-1:0] dout_q;
  logic [ILEN-1:0] iout_q, iout_d;

  logic [AW-1:0]   dword, iword;
  logic [DLEN-1:0] old_w, merged, ld_shift, ld_data, rd_res;
  logic            mis, oor, err_now, wr_en;
  logic            unused_ibits;

  assign unused_ibits = ^iaddr[1:0];

  always_comb begin
    dword    = addr_q[AW+2:3];
    old_w    = mem[dword];
    mis      = |(addr_q[2:0] & ((3'd1 << size_q) - 3'd1));
    oor      = addr_q[XLEN-1:3] >= (XLEN-3)'(DEPTH);
    err_now  = mis || oor || (kind_q == RQ_ERR);
    wr_en    = (state_q == DONE) && (kind_q == RQ_ST) && !err_now;
    ld_shift = old_w >> {addr_q[2:0], 3'b000};
    case (size_q)
      SZ_B:    ld_data = {56'd0, ld_shift[7:0]};
      SZ_H:    ld_data = {48'd0, ld_shift[15:0]};
      SZ_W:    ld_data = {32'd0, ld_shift[31:0]};
      default: ld_data = ld_shift;
    endcase
    rd_res = (kind_q == RQ_LD && !err_now) ? ld_data : '0;
    iword  = iaddr[AW+2:3];
    iout_d = '0;
    if (iaddr[XLEN-1:3] < (XLEN-3)'(DEPTH))
      iout_d = iaddr[2] ? mem[iword][63:32] : mem[iword][31:0];
  end

  risci_lane_merge u_merge (
    .size    (size_q),
    .offset  (addr_q[2:0]),
    .old_word(old_w),
    .new_data(wdata_q),
    .merged  (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      kind_q   <= RQ_LD;
      size_q   <= SZ_B;
      addr_q   <= '0;
      wdata_q  <= '0;
      dready_q <= 1'b0;
      derr_q   <= 1'b0;
      dout_q   <= '0;
      iout_q   <= '0;
    end else begin
      iout_q   <= iout_d;
      dready_q <= 1'b0;
      case (state_q)
        IDLE: if (re || we) begin
          addr_q  <= daddr;
          wdata_q <= din;
          size_q  <= size_e'(dlen);
          kind_q  <= (re && we) ? RQ_ERR : (we ? RQ_ST : RQ_LD);
          if (LAT == 1) begin
            state_q  <= DONE;
            dready_q <= 1'b1;
          end else begin
            state_q <= WAIT;
            cnt_q   <= 4'(LAT - 1);
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q  <= DONE;
            dready_q <= 1'b1;
          end
        end
        DONE: begin
          // Latch the completion result so it holds until the next dready.
          state_q <= IDLE;
          derr_q  <= err_now;
          dout_q  <= rd_res;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is never reset; a reset landing in DONE suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[dword] <= merged;
  end

  assign iout   = iout_q;
  assign dready = dready_q;
  assign derr   = dready_q ? err_now : derr_q;
  assign dout   = dready_q ? rd_res : dout_q;
endmodule

// File: tb/tb_risci_memory.sv
// Directed bench for risci_memory: expectations are queued at issue time and
// checked by an independent monitor on each dready pulse.
module tb_risci_memory;
  import risci_pkg::*;
  localparam int DEPTH = 512;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] iaddr, daddr, din, dout;
  logic [31:0] iout;
  logic [1:0]  dlen;
  logic        re, we, dready, derr;

  risci_memory #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .iaddr(iaddr), .iout(iout), .daddr(daddr), .din(din),
    .dout(dout), .dlen(dlen), .re(re), .we(we), .dready(dready), .derr(derr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        derr;
    logic [63:0] dout;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] xp);
    n_vec++;
    if (act !== xp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, xp);
    end
  endtask

  // Monitor: every dready must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && dready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_dready: got dready=1 at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_derr"}, 64'(derr), 64'(e.derr));
        chk({e.name, "_dout"}, dout, e.dout);
        chk({e.name, "_lat"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input string nm, input logic r, input logic w, input logic [1:0] sz,
                       input logic [63:0] a, input logic [63:0] d, input logic xerr,
                       input logic [63:0] xdout, input bit expect_done);
    exp_t e;
    e.name = nm; e.derr = xerr; e.dout = xdout; e.cyc = cyc + LAT;
    if (expect_done) sb.push_back(e);
    re = r; we = w; dlen = sz; daddr = a; din = d;
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got no dready expected one within 30 cycles", nm);
      sb.delete();
    end
  endtask

  task automatic acc(input string nm, input logic r, input logic w, input logic [1:0] sz,
                     input logic [63:0] a, input logic [63:0] d, input logic xerr,
                     input logic [63:0] xdout);
    issue(nm, r, w, sz, a, d, xerr, xdout, 1'b1);
    wait_done(nm);
  endtask

  initial begin
    rst = 1'b1; re = 1'b0; we = 1'b0; iaddr = 64'h14; daddr = '0; din = '0; dlen = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dready", 64'(dready), 64'd0);
    chk("rst_derr",   64'(derr),   64'd0);
    chk("rst_dout",   dout,        64'd0);
    chk("rst_iout",   64'(iout),   64'd0);
    rst = 1'b0;

    acc("st_d_10",  0, 1, SZ_D, 64'h10, 64'h1122334455667788, 0, 64'h0);
    acc("ld_d_10",  1, 0, SZ_D, 64'h10, 64'h0, 0, 64'h1122334455667788);
    acc("st_b_12",  0, 1, SZ_B, 64'h12, 64'hAB, 0, 64'h0);
    acc("ld_w_10a", 1, 0, SZ_W, 64'h10, 64'h0, 0, 64'h55AB7788);
    acc("st_b_13",  0, 1, SZ_B, 64'h13, 64'hFFFFFFFF_FFFFFFCD, 0, 64'h0);
    acc("ld_w_10b", 1, 0, SZ_W, 64'h10, 64'h0, 0, 64'hCDAB7788);
    acc("ld_h_11",  1, 0, SZ_H, 64'h11, 64'h0, 1, 64'h0);
    acc("ld_d_10c", 1, 0, SZ_D, 64'h10, 64'h0, 0, 64'h11223344_CDAB7788);
    acc("ld_d_oor", 1, 0, SZ_D, 64'h1000, 64'h0, 1, 64'h0);
    acc("st_w_mis", 0, 1, SZ_W, 64'h16, 64'h0, 1, 64'h0);
    acc("ld_h_16",  1, 0, SZ_H, 64'h16, 64'h0, 0, 64'h1122);
    acc("rw_both",  1, 1, SZ_D, 64'h10, 64'h0, 1, 64'h0);

    // Second re while the first load is still waiting must be dropped.
    issue("ld_d_busy", 1, 0, SZ_D, 64'h10, 64'h0, 0, 64'h11223344_CDAB7788, 1'b1);
    issue("ld_ignored", 1, 0, SZ_B, 64'h18, 64'h0, 0, 64'h0, 1'b0);
    wait_done("ld_d_busy");
    repeat (5) @(posedge clk);
    #1;

    // Fetch sees the pre-store word on the store's completion edge.
    iaddr = 64'h14;
    acc("st_w_14", 0, 1, SZ_W, 64'h14, 64'hDEADBEEF, 0, 64'h0);
    chk("fetch_old", 64'(iout), 64'h11223344);
    @(posedge clk); #1;
    chk("fetch_new", 64'(iout), 64'hDEADBEEF);
    iaddr = 64'h1000;
    @(posedge clk); #1;
    chk("fetch_oor", 64'(iout), 64'h0);
    iaddr = 64'h10;
    @(posedge clk); #1;
    chk("fetch_lo", 64'(iout), 64'hCDAB7788);

    // Reset in the middle of a store aborts it.
    acc("st_d_18", 0, 1, SZ_D, 64'h18, 64'h01234567_89ABCDEF, 0, 64'h0);
    issue("st_abort", 0, 1, SZ_D, 64'h18, 64'h55555555_55555555, 0, 64'h0, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_dready", 64'(dready), 64'd0);
    chk("abort_iout",   64'(iout),   64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    acc("ld_d_18", 1, 0, SZ_D, 64'h18, 64'h0, 0, 64'h01234567_89ABCDEF);
    chk("dout_hold", dout, 64'h01234567_89ABCDEF);
    chk("derr_hold", 64'(derr), 64'd0);
    repeat (5) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
